// File: rtl/uart_rx_if.sv
// Serial-receive bundle for uart_rx: the serial line in, the received word and status pulses out.
// The slave modport is the receiver's view; the master modport is the line driver/consumer view.
interface uart_rx_if #(
  parameter int ANCHO = 8
);
  logic             rx_i;
  logic [ANCHO-1:0] dato_o;
  logic             valido_o;
  logic             error_trama_o;
  logic             error_paridad_o;
  logic             ocupado_o;

  modport slave (
    input  rx_i,
    output dato_o, valido_o, error_trama_o, error_paridad_o, ocupado_o
  );

  modport master (
    output rx_i,
    input  dato_o, valido_o, error_trama_o, error_paridad_o, ocupado_o
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling, stop-bit framing check.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data and stop bits.
module uart_rx #(
  parameter int ANCHO          = 8,
  parameter int CICLOS_POR_BIT = 10416
) (
  input  logic       clk_i,
  input  logic       rst_i,
  uart_rx_if.slave   bus
);

  localparam int CW = $clog2(CICLOS_POR_BIT);
  localparam int IW = $clog2(ANCHO);
  localparam logic [CW-1:0] CNT_BIT   = CW'(CICLOS_POR_BIT - 1);
  // Edge detection already costs one cycle, so the half-bit wait ends one count early.
  localparam logic [CW-1:0] CNT_MEDIO = CW'(CICLOS_POR_BIT / 2 - 2);
  localparam logic [IW-1:0] IDX_ULT   = IW'(ANCHO - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {REPOSO, INICIO, DATOS, PARIDAD, PARADA} estado_t;
`else
  typedef enum logic [2:0] {REPOSO, INICIO, DATOS, PARADA} estado_t;
`endif

  estado_t          estado_q, estado_d;
  logic             sync1_q, sync1_d;
  logic             rx_s_q, rx_s_d;
  logic             rx_prev_q, rx_prev_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [ANCHO-1:0] sr_q, sr_d;
  logic [ANCHO-1:0] dato_q, dato_d;
  logic             valido_q, valido_d;
  logic             err_trama_q, err_trama_d;
`ifdef UART_RX_PARITY_EN
  logic             perr_q, perr_d;
  logic             err_par_q, err_par_d;
`endif

  always_comb begin
    sync1_d     = bus.rx_i;
    rx_s_d      = sync1_q;
    rx_prev_d   = rx_s_q;
    estado_d    = estado_q;
    cnt_d       = cnt_q + 1'b1;
    idx_d       = idx_q;
    sr_d        = sr_q;
    dato_d      = dato_q;
    valido_d    = 1'b0;
    err_trama_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d      = perr_q;
    err_par_d   = 1'b0;
`endif
    case (estado_q)
      REPOSO: begin
        cnt_d = '0;
        idx_d = '0;
        if (rx_prev_q && !rx_s_q) estado_d = INICIO;
      end
      INICIO: begin
        if (cnt_q == CNT_MEDIO) begin
          cnt_d    = '0;
          estado_d = rx_s_q ? REPOSO : DATOS;
        end
      end
      DATOS: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d = '0;
          sr_d  = {rx_s_q, sr_q[ANCHO-1:1]};
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_ULT) begin
            idx_d = '0;
`ifdef UART_RX_PARITY_EN
            estado_d = PARIDAD;
`else
            estado_d = PARADA;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARIDAD: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d    = '0;
          perr_d   = (^sr_q) ^ rx_s_q;
          estado_d = PARADA;
        end
      end
`endif
      PARADA: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d    = '0;
          estado_d = REPOSO;
          if (rx_s_q) begin
            dato_d   = sr_q;
            valido_d = 1'b1;
          end else begin
            err_trama_d = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          err_par_d = perr_q;
          perr_d    = 1'b0;
`endif
        end
      end
      default: estado_d = REPOSO;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      estado_q    <= REPOSO;
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      cnt_q       <= '0;
      idx_q       <= '0;
      sr_q        <= '0;
      dato_q      <= '0;
      valido_q    <= 1'b0;
      err_trama_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q      <= 1'b0;
      err_par_q   <= 1'b0;
`endif
    end else begin
      estado_q    <= estado_d;
      sync1_q     <= sync1_d;
      rx_s_q      <= rx_s_d;
      rx_prev_q   <= rx_prev_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sr_q        <= sr_d;
      dato_q      <= dato_d;
      valido_q    <= valido_d;
      err_trama_q <= err_trama_d;
`ifdef UART_RX_PARITY_EN
      perr_q      <= perr_d;
      err_par_q   <= err_par_d;
`endif
    end
  end

  assign bus.dato_o        = dato_q;
  assign bus.valido_o      = valido_q;
  assign bus.error_trama_o = err_trama_q;
  assign bus.ocupado_o     = (estado_q != REPOSO);
`ifdef UART_RX_PARITY_EN
  assign bus.error_paridad_o = err_par_q;
`else
  assign bus.error_paridad_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (ANCHO=8, CICLOS_POR_BIT=16): vector table plus corner-case sequences,
// with every status pulse checked against a queue of expected frame outcomes.
module tb_uart_rx;
  localparam int C = 16;
  localparam int W = 8;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  typedef struct {
    logic [7:0] dato;
    logic       stop_ok;
    logic       par_ok;
    logic       exp_valido;
    logic       exp_trama;
    logic       exp_paridad;
    logic [7:0] exp_dato;
  } vec_t;

  typedef struct {
    logic       valido;
    logic       trama;
    logic       paridad;
    logic [7:0] dato;
  } evento_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  int   t_valido = 0;
  evento_t exp_q[$];
  vec_t    tabla[$];

  uart_rx_if #(.ANCHO(W)) bus();

  uart_rx #(.ANCHO(W), .CICLOS_POR_BIT(C)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    evento_t e;
    forever begin
      @(negedge clk_i);
      if (bus.valido_o || bus.error_trama_o || bus.error_paridad_o) begin
        if (bus.valido_o) t_valido = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got v=%0b t=%0b p=%0b expected none (cycle %0d)",
                   bus.valido_o, bus.error_trama_o, bus.error_paridad_o, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", 32'({bus.valido_o, bus.error_trama_o, bus.error_paridad_o}),
              32'({e.valido, e.trama, e.paridad}));
          chk("dato", 32'(bus.dato_o), 32'(e.dato));
        end
      end
    end
  endtask

  task automatic send_bit(input logic b);
    bus.rx_i = b;
    repeat (C) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok, input int idle);
    send_bit(1'b0);
    for (int i = 0; i < W; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ ~par_ok);
`endif
    send_bit(stop);
    bus.rx_i = 1'b1;
    repeat (idle) @(negedge clk_i);
  endtask

  task automatic expect_evt(input logic v, input logic t, input logic p, input logic [7:0] d);
    evento_t e;
    e.valido  = v;
    e.trama   = t;
    e.paridad = p;
    e.dato    = d;
    exp_q.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dato"},    32'(bus.dato_o), 32'h0);
    chk({tag, "_valido"},  32'(bus.valido_o), 32'h0);
    chk({tag, "_trama"},   32'(bus.error_trama_o), 32'h0);
    chk({tag, "_paridad"}, 32'(bus.error_paridad_o), 32'h0);
    chk({tag, "_ocupado"}, 32'(bus.ocupado_o), 32'h0);
  endtask

  initial begin
    int start_cyc;
    int k;
    vec_t v;

    tabla.push_back('{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5});
    tabla.push_back('{8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5});
    tabla.push_back('{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00});
    tabla.push_back('{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF});
    tabla.push_back('{8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF});
    tabla.push_back('{8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A});
`ifdef UART_RX_PARITY_EN
    tabla.push_back('{8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h07});
    tabla.push_back('{8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h07});
    tabla.push_back('{8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h07});
`endif

    bus.rx_i = 1'b1;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk_i);
    chk_reset_outputs("reset");
    rst_i = 1'b0;
    repeat (2 * C) @(negedge clk_i);

    // Latency from first low synchronized sample to valido, plus 2 synchronizer cycles.
    expect_evt(1'b1, 1'b0, 1'b0, 8'hA5);
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1, 1'b1, 2 * C);
    chk("latency", 32'(t_valido - start_cyc), 32'(2 + C / 2 + (W + 1 + P) * C));

    foreach (tabla[i]) begin
      v = tabla[i];
      expect_evt(v.exp_valido, v.exp_trama, v.exp_paridad, v.exp_dato);
      send_frame(v.dato, v.stop_ok, v.par_ok, 2 * C);
    end

    // Short low glitch: must be rejected with no pulses.
    bus.rx_i = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("glitch_started", 32'(bus.ocupado_o), 32'h1);
    bus.rx_i = 1'b1;
    for (k = 0; k < 8; k++) begin
      @(negedge clk_i);
      if (!bus.ocupado_o) break;
    end
    chk("glitch_ocupado", 32'(bus.ocupado_o), 32'h0);
    repeat (2 * C) @(negedge clk_i);

    // Back-to-back frames with no idle gap.
    expect_evt(1'b1, 1'b0, 1'b0, 8'h00);
    expect_evt(1'b1, 1'b0, 1'b0, 8'hFF);
    send_frame(8'h00, 1'b1, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 1'b1, 2 * C);
    chk("b2b_dato", 32'(bus.dato_o), 32'hFF);

    // Reset in the middle of data bit 3.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    bus.rx_i = 1'b0;
    repeat (C / 2) @(negedge clk_i);
    rst_i = 1'b1;
    bus.rx_i = 1'b1;
    @(negedge clk_i);
    chk_reset_outputs("midreset");
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3 * C) @(negedge clk_i);
    chk("post_reset_idle", 32'(bus.ocupado_o), 32'h0);
    expect_evt(1'b1, 1'b0, 1'b0, 8'h5A);
    send_frame(8'h5A, 1'b1, 1'b1, 2 * C);

    repeat (C) @(negedge clk_i);
    chk("pending_expectations", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
Parameters:
REQ-001 ANCHO, default 8, number of data bits per frame; SHALL be legal for values 5..9.
REQ-002 CICLOS_POR_BIT, default 10416, clk_i cycles per bit (100 MHz / 9600 baud); SHALL be legal for values >= 4.
Ports:
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 rx_i  input  1  serial line, asynchronous to clk_i, idle high.
REQ-006 dato_o  output  ANCHO  last correctly framed word, LSB received first.
REQ-007 valido_o  output  1  one-cycle pulse; dato_o is new in this cycle.
REQ-008 error_trama_o  output  1  one-cycle pulse; stop bit sampled low.
REQ-009 error_paridad_o  output  1  one-cycle pulse; parity mismatch (see Configuration).
REQ-010 ocupado_o  output  1  high in every state except REPOSO.

Function
REQ-011 rx_i SHALL pass through a 2-flop synchronizer; "rx_s" below denotes the synchronizer output, and all decisions SHALL use rx_s only.
REQ-012 Frame format SHALL be: 1 start bit (0), ANCHO data bits LSB first, an optional parity bit, 1 stop bit (1).
REQ-013 FSM states SHALL be REPOSO, INICIO, DATOS, PARIDAD, PARADA; PARIDAD SHALL be reachable only when the parity option is compiled in.
REQ-014 REPOSO -> INICIO SHALL occur on a falling edge of rx_s (previous sample 1, current sample 0); a constant-low line SHALL NOT start a frame.
REQ-015 INICIO SHALL wait CICLOS_POR_BIT/2 cycles (integer division) and then sample rx_s: a 0 SHALL go to DATOS, a 1 SHALL return to REPOSO (glitch rejection) with no output pulses.
REQ-016 DATOS SHALL sample rx_s every CICLOS_POR_BIT cycles, ANCHO times, shifting each sample into the MSB of an internal shift register.
REQ-017 After DATOS, the FSM SHALL go to PARIDAD if the parity option is enabled, otherwise directly to PARADA.
REQ-018 PARIDAD SHALL take its sample CICLOS_POR_BIT cycles after the previous sample.
REQ-019 PARADA SHALL take its sample CICLOS_POR_BIT cycles after the previous sample.
REQ-020 In PARADA, a sample of 1 SHALL load dato_o from the shift register and pulse valido_o in the same cycle.
REQ-021 In PARADA, a sample of 0 SHALL pulse error_trama_o, and dato_o SHALL hold its previous value.
REQ-022 After the PARADA sample the FSM SHALL enter REPOSO on the next cycle, so that a start bit immediately following the stop bit is accepted.
REQ-023 Latency: with cycle 0 defined as the cycle rx_s is first sampled low, valido_o SHALL assert at cycle CICLOS_POR_BIT/2 + (ANCHO+1+P)*CICLOS_POR_BIT, where P is 1 with parity and 0 without.
REQ-024 The bit counter SHALL be $clog2(CICLOS_POR_BIT) bits wide and SHALL reload to 0 at every sample; it SHALL never wrap mid-bit.
REQ-025 valido_o, error_trama_o and error_paridad_o SHALL each be high for exactly one cycle per frame; valido_o and error_trama_o SHALL be mutually exclusive.

Reset
REQ-026 While rst_i is high, the FSM SHALL be in REPOSO; dato_o, the shift register and the counters SHALL be 0; valido_o, error_trama_o, error_paridad_o and ocupado_o SHALL be 0; both synchronizer flops SHALL be 1.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no pulses.
REQ-028 After reset deasserts, reception SHALL resume only on a fresh falling edge of rx_s.

Configuration
REQ-029 Macro UART_RX_PARITY_EN defined: an even-parity bit SHALL be expected after the data bits; a mismatch SHALL pulse error_paridad_o in the PARADA sample cycle, and valido_o and dato_o SHALL still follow the stop bit rules.
REQ-030 Macro UART_RX_PARITY_EN undefined: there SHALL be no parity bit and no PARIDAD state, and error_paridad_o SHALL be tied to 0.

Verification (CICLOS_POR_BIT=16, ANCHO=8)
REQ-031 Frame 0xA5 with a valid stop bit -> dato_o=8'hA5, valido_o high for exactly one cycle at latency 8+9*16=152 cycles, no error pulses.
REQ-032 Frame 0x3C with stop bit 0 -> error_trama_o pulses once, valido_o stays 0, dato_o keeps its prior value.
REQ-033 rx_i low for 4 cycles, then high -> no pulses, and ocupado_o returns to 0 within 8 cycles.
REQ-034 Back-to-back 0x00 then 0xFF with no idle gap -> two valido_o pulses with dato_o=0x00 then 0xFF.
REQ-035 rst_i pulsed during data bit 3 of a frame -> no pulses, outputs at reset values; the next full frame 0x5A is received correctly.
REQ-036 UART_RX_PARITY_EN defined, data 0x07 with parity bit 0 -> error_paridad_o pulses and valido_o pulses with dato_o=0x07; with parity bit 1 -> no error.
